ps2_move_entry: RTL and testbench
=================================

# ps2_move_entry

Parametrised keyboard move-entry front end for the chess board datapath. Filters the raw PS/2 scan-code stream (break and extended prefixes), assembles file/rank coordinate pairs into one of `NUM_SLOTS` entry slots, and delivers each completed square as a single held write to processor memory. The write uses a ready handshake, so no square is lost when the memory port is busy. It sits between the PS/2 controller and the memory write-arbitration mux.

## Interface
- `NUM_SLOTS`, 2: number of coordinate slots (slot 0 = source square, slot 1 = destination square, …); must be ≥1.
- `ADDR_BASE`, 64: memory address of slot 0; slot s writes to `ADDR_BASE+s`.
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: write-data width; must be ≥7.
- `clock` in 1: the single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_key_data` in 8: scan-code byte; valid when `ps2_key_pressed`=1.
- `ps2_key_pressed` in 1: one-cycle strobe marking a new byte.
- `keyboard_ready` in 1: memory port accepts the write this cycle.
- `keyboard_we` out 1: write request, held until accepted.
- `keyboard_write_address` out ADDR_W: `ADDR_BASE + write_slot`.
- `keyboard_write_data` out DATA_W: {zeros, done, rank[2:0], file[2:0]}.
- `active_slot` out clog2(NUM_SLOTS) (min 1): slot currently being filled.
- `partial` out 2: {rank_valid, file_valid} of the active slot.

## Operation
- **Prefix filter FSM**, 4 states, advancing only on a `ps2_key_pressed` strobe:
  - NORMAL: F0→BREAK; E0→EXT; other bytes are make codes.
  - BREAK: any byte is discarded, then →NORMAL.
  - EXT: F0→EXT_BREAK; other bytes are extended make codes, then →NORMAL.
  - EXT_BREAK: any byte is discarded, then →NORMAL.
- **Make codes.** Typematic repeats are treated as fresh makes.
  - Letters 1C,32,21,23,24,2B,34,33 (A–H) set file = 0–7 and file_valid.
  - Digits 16,1E,26,25,2E,36,3D,3E (1–8) set rank = 0–7 and rank_valid.
  - Letter and digit may arrive in either order; a repeated letter or digit overwrites the earlier one.
  - 66 (Backspace) clears the most recently entered coordinate of the active slot. If neither coordinate is valid, it moves `active_slot` back one, saturating at 0.
  - 76 (Esc) clears all slots, sets `active_slot`=0, and cancels a pending write.
  - Any other code is ignored.
- **Extended make codes.**
  - E0 6B (left) moves to the previous slot, wrapping NUM_SLOTS-1→0 in reverse, and clears that slot's partial entry.
  - E0 74 (right) moves to the next slot, with wrap, and clears that slot's partial entry.
- **Entry FSM**: COLLECT → PEND → COLLECT.
  - COLLECT→PEND: entered when both coordinates become valid. The square is latched into the output register and the slot's partials are cleared.
  - In PEND: `keyboard_we`=1, with address and data stable.
  - PEND→COLLECT: on a cycle with `keyboard_ready`=1. At that edge `active_slot` advances with wrap.
  - `done` bit (data bit 6) = 1 when the written slot is NUM_SLOTS-1, which marks a complete move for software.
  - During PEND, the prefix FSM keeps tracking. Make codes other than Esc are discarded.
- Reset values:
  - `keyboard_we`=0, `keyboard_write_data`=0, `keyboard_write_address`=ADDR_BASE, `active_slot`=0, `partial`=00.
  - Prefix FSM=NORMAL, entry FSM=COLLECT.

## Timing
- Completing a key is registered at edge N, with `keyboard_we`=1 from N+1. If `keyboard_ready`=1 at N+1, the write retires with exactly one cycle of `we`.
- One write at most every 2 cycles.
- Esc and `keyboard_ready` in the same cycle: Esc wins, so the write is dropped and `we` falls.
- `resetn` asserted mid-PEND: `we` drops asynchronously and no write occurs.
- Strobes on consecutive cycles are all processed; the block never stalls the PS/2 side.

## Structure
- `chess_kbd_pkg` holds:
  - scan-code constants: letters, digits, F0, E0, 66, 76, 6B, 74;
  - prefix-state and entry-state enums;
  - the `scan_to_coord` function, which returns {is_letter, is_digit, val[2:0]}.
- One sub-module, `ps2_prefix_filter`. It takes the raw strobe and byte, and emits a one-cycle `make_valid`, `make_ext` and `make_code`, registered.
  - Alternative: keep it combinational and have the top-level account for the added cycle. The N+1 latency above is measured from the filter output.

## Test plan
- Press D (23) then 4 (25), each followed by F0+code, with `keyboard_ready`=1. Expect one write at address 64 with data 0x1B (rank 3, file 3, done 0), then `active_slot`=1.
- Press 5 (2E) then E (24) into slot 1 with `keyboard_ready` held 0 for 10 cycles. Expect `we` held for 10 cycles with constant address 65 and data 0x64, retiring on the first ready. The G press during PEND is ignored.
- Press A (1C) then F0 1E. Expect release filtered, `partial`=01, no write.
- Press C (21) then Backspace. Expect `partial`=00. A second Backspace moves `active_slot` 1→0.
- E0 74 with NUM_SLOTS=3 and slot=2 → slot 0. E0 F0 74 → no change. E0 6B from slot 0 → slot 2.
- In PEND, press Esc in the same cycle as `keyboard_ready`=1. Expect no write and `active_slot`=0. Assert `resetn`=0 mid-PEND and expect all outputs at reset values immediately.

Source files
------------

// File: rtl/chess_kbd_pkg.sv
// rtl/chess_kbd_pkg.sv - scan-code constants, state enums and coordinate decode for keyboard move entry
package chess_kbd_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_E     = 8'h24;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        PFX_NORMAL,
        PFX_BREAK,
        PFX_EXT,
        PFX_EXT_BREAK
    } pfx_state_t;

    typedef enum logic {
        ENT_COLLECT,
        ENT_PEND
    } ent_state_t;

    // Returns {is_letter, is_digit, val[2:0]}; both flags clear for any other code.
    function automatic logic [4:0] scan_to_coord(input logic [7:0] code);
        case (code)
            SC_A:    return {2'b10, 3'd0};
            SC_B:    return {2'b10, 3'd1};
            SC_C:    return {2'b10, 3'd2};
            SC_D:    return {2'b10, 3'd3};
            SC_E:    return {2'b10, 3'd4};
            SC_F:    return {2'b10, 3'd5};
            SC_G:    return {2'b10, 3'd6};
            SC_H:    return {2'b10, 3'd7};
            SC_1:    return {2'b01, 3'd0};
            SC_2:    return {2'b01, 3'd1};
            SC_3:    return {2'b01, 3'd2};
            SC_4:    return {2'b01, 3'd3};
            SC_5:    return {2'b01, 3'd4};
            SC_6:    return {2'b01, 3'd5};
            SC_7:    return {2'b01, 3'd6};
            SC_8:    return {2'b01, 3'd7};
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_prefix_filter.sv
// rtl/ps2_prefix_filter.sv - strips break/extended prefixes, emits registered one-cycle make codes
module ps2_prefix_filter
    import chess_kbd_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] i_key_data,
    input  logic       i_key_pressed,
    output logic       o_make_valid,
    output logic       o_make_ext,
    output logic [7:0] o_make_code
);

    pfx_state_t r_state;
    pfx_state_t w_state_next;
    logic       r_make_valid;
    logic       r_make_ext;
    logic [7:0] r_make_code;
    logic       w_make_valid;
    logic       w_make_ext;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= PFX_NORMAL;
            r_make_valid <= 1'b0;
            r_make_ext   <= 1'b0;
            r_make_code  <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_make_valid <= w_make_valid;
            r_make_ext   <= w_make_ext;
            if (i_key_pressed)
                r_make_code <= i_key_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_key_pressed) begin
            case (r_state)
                PFX_NORMAL: begin
                    if (i_key_data == SC_BREAK)
                        w_state_next = PFX_BREAK;
                    else if (i_key_data == SC_EXT)
                        w_state_next = PFX_EXT;
                end
                PFX_EXT: begin
                    if (i_key_data == SC_BREAK)
                        w_state_next = PFX_EXT_BREAK;
                    else
                        w_state_next = PFX_NORMAL;
                end
                default: w_state_next = PFX_NORMAL;
            endcase
        end
    end

    always_comb begin
        w_make_valid = 1'b0;
        w_make_ext   = 1'b0;
        if (i_key_pressed) begin
            if (r_state == PFX_NORMAL && i_key_data != SC_BREAK && i_key_data != SC_EXT) begin
                w_make_valid = 1'b1;
            end else if (r_state == PFX_EXT && i_key_data != SC_BREAK) begin
                w_make_valid = 1'b1;
                w_make_ext   = 1'b1;
            end
        end
    end

    assign o_make_valid = r_make_valid;
    assign o_make_ext   = r_make_ext;
    assign o_make_code  = r_make_code;

endmodule

// File: rtl/ps2_move_entry.sv
// rtl/ps2_move_entry.sv - assembles file/rank key pairs into slots and writes each square with a ready handshake
module ps2_move_entry
    import chess_kbd_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int ADDR_BASE = 64,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    localparam int SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [7:0]        ps2_key_data,
    input  logic              ps2_key_pressed,
    input  logic              keyboard_ready,
    output logic              keyboard_we,
    output logic [ADDR_W-1:0] keyboard_write_address,
    output logic [DATA_W-1:0] keyboard_write_data,
    output logic [SW-1:0]     active_slot,
    output logic [1:0]        partial
);

    // Slot storage is padded to a power of two so the slot index always fits the arrays exactly.
    localparam int            NS   = 1 << SW;
    localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);

    logic              w_make_valid;
    logic              w_make_ext;
    logic [7:0]        w_make_code;

    ent_state_t        r_state;
    ent_state_t        w_state_next;
    logic [SW-1:0]     r_slot;
    logic [SW-1:0]     w_slot_next;
    logic [SW-1:0]     w_slot_prev;
    logic [2:0]        r_file [NS];
    logic [2:0]        r_rank [NS];
    logic [NS-1:0]     r_fv;
    logic [NS-1:0]     r_rv;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic [4:0]        w_coord;
    logic              w_is_letter;
    logic              w_is_digit;
    logic [2:0]        w_val;
    logic              w_key;
    logic              w_esc;
    logic              w_cur_fv;
    logic              w_cur_rv;
    logic              w_complete;
    logic [2:0]        w_sq_file;
    logic [2:0]        w_sq_rank;

    ps2_prefix_filter u_filter (
        .clock         (clock),
        .resetn        (resetn),
        .i_key_data    (ps2_key_data),
        .i_key_pressed (ps2_key_pressed),
        .o_make_valid  (w_make_valid),
        .o_make_ext    (w_make_ext),
        .o_make_code   (w_make_code)
    );

    assign w_coord     = scan_to_coord(w_make_code);
    assign w_is_letter = w_coord[4];
    assign w_is_digit  = w_coord[3];
    assign w_val       = w_coord[2:0];
    assign w_key       = w_make_valid & ~w_make_ext;
    assign w_esc       = w_key && (w_make_code == SC_ESC);
    assign w_cur_fv    = r_fv[r_slot];
    assign w_cur_rv    = r_rv[r_slot];
    assign w_complete  = (r_state == ENT_COLLECT) && w_key &&
                         ((w_is_letter && w_cur_rv) || (w_is_digit && w_cur_fv));
    assign w_sq_file   = w_is_letter ? w_val : r_file[r_slot];
    assign w_sq_rank   = w_is_digit  ? w_val : r_rank[r_slot];
    assign w_slot_next = (r_slot == LAST) ? '0 : r_slot + SW'(1);
    assign w_slot_prev = (r_slot == '0) ? LAST : r_slot - SW'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= ENT_COLLECT;
        else
            r_state <= w_state_next;
    end

    // Esc takes priority over a same-cycle ready, so a pending write is dropped rather than retired.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ENT_COLLECT: if (w_complete) w_state_next = ENT_PEND;
            ENT_PEND:    if (w_esc || keyboard_ready) w_state_next = ENT_COLLECT;
            default:     w_state_next = ENT_COLLECT;
        endcase
    end

    always_comb begin
        keyboard_we = (r_state == ENT_PEND);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
            r_fv   <= '0;
            r_rv   <= '0;
            r_addr <= ADDR_W'(ADDR_BASE);
            r_data <= '0;
            for (int i = 0; i < NS; i++) begin
                r_file[i] <= 3'd0;
                r_rank[i] <= 3'd0;
            end
        end else if (w_esc) begin
            r_slot <= '0;
            r_fv   <= '0;
            r_rv   <= '0;
        end else if (r_state == ENT_PEND) begin
            if (keyboard_ready)
                r_slot <= w_slot_next;
        end else if (w_complete) begin
            r_data       <= DATA_W'({(r_slot == LAST), w_sq_rank, w_sq_file});
            r_addr       <= ADDR_W'(ADDR_BASE) + ADDR_W'(r_slot);
            r_fv[r_slot] <= 1'b0;
            r_rv[r_slot] <= 1'b0;
        end else if (w_key) begin
            if (w_is_letter) begin
                r_file[r_slot] <= w_val;
                r_fv[r_slot]   <= 1'b1;
            end else if (w_is_digit) begin
                r_rank[r_slot] <= w_val;
                r_rv[r_slot]   <= 1'b1;
            end else if (w_make_code == SC_BKSP) begin
                // At most one coordinate is ever held, so it is the most recent one.
                if (w_cur_fv)
                    r_fv[r_slot] <= 1'b0;
                else if (w_cur_rv)
                    r_rv[r_slot] <= 1'b0;
                else if (r_slot != '0)
                    r_slot <= r_slot - SW'(1);
            end
        end else if (w_make_valid && w_make_ext) begin
            if (w_make_code == SC_LEFT) begin
                r_slot            <= w_slot_prev;
                r_fv[w_slot_prev] <= 1'b0;
                r_rv[w_slot_prev] <= 1'b0;
            end else if (w_make_code == SC_RIGHT) begin
                r_slot            <= w_slot_next;
                r_fv[w_slot_next] <= 1'b0;
                r_rv[w_slot_next] <= 1'b0;
            end
        end
    end

    assign keyboard_write_address = r_addr;
    assign keyboard_write_data    = r_data;
    assign active_slot            = r_slot;
    assign partial                = {w_cur_rv, w_cur_fv};

endmodule

// File: tb/tb_ps2_move_entry.sv
// tb/tb_ps2_move_entry.sv - scoreboard bench for ps2_move_entry
module tb_ps2_move_entry;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  kd, kd3;
    logic        kp, kp3;
    logic        rdy, rdy3;
    logic        we, we3;
    logic [11:0] addr, addr3;
    logic [31:0] data, data3;
    logic [0:0]  slot;
    logic [1:0]  slot3;
    logic [1:0]  part, part3;

    int          checks = 0;
    int          errors = 0;
    logic [43:0] exp_q[$];
    logic [43:0] e;
    bit          skip_mon = 0;
    int          held;

    always #5 clock = ~clock;

    ps2_move_entry #(.NUM_SLOTS(2), .ADDR_BASE(64), .ADDR_W(12), .DATA_W(32)) dut (
        .clock(clock), .resetn(resetn), .ps2_key_data(kd), .ps2_key_pressed(kp),
        .keyboard_ready(rdy), .keyboard_we(we), .keyboard_write_address(addr),
        .keyboard_write_data(data), .active_slot(slot), .partial(part)
    );

    ps2_move_entry #(.NUM_SLOTS(3), .ADDR_BASE(64), .ADDR_W(12), .DATA_W(32)) dut3 (
        .clock(clock), .resetn(resetn), .ps2_key_data(kd3), .ps2_key_pressed(kp3),
        .keyboard_ready(rdy3), .keyboard_we(we3), .keyboard_write_address(addr3),
        .keyboard_write_data(data3), .active_slot(slot3), .partial(part3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        kd = b; kp = 1'b1;
        tick();
        kp = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b);
        kd3 = b; kp3 = 1'b1;
        tick();
        kp3 = 1'b0;
    endtask

    task automatic wait_we(input string name);
        int n = 0;
        while (!we && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, we}, 32'd1);
    endtask

    // Monitor: every accepted write must match the head of the expected queue.
    always @(negedge clock) begin
        if (resetn && we && rdy && !skip_mon) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", addr, data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {20'd0, addr}, {20'd0, e[43:32]});
                chk("write_data", data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; kd = 8'h00; kp = 1'b0; rdy = 1'b0; kd3 = 8'h00; kp3 = 1'b0; rdy3 = 1'b0;
        idle(2);
        resetn = 1'b1;
        tick();
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_addr", {20'd0, addr}, 32'd64);
        chk("reset_data", data, 32'd0);
        chk("reset_slot", {31'd0, slot}, 32'd0);
        chk("reset_partial", {30'd0, part}, 32'd0);
        chk("reset_slot3", {30'd0, slot3}, 32'd0);

        // D then 4 with releases, ready held high
        rdy = 1'b1;
        exp_q.push_back({12'd64, 32'h0000_001B});
        send(8'h23); send(8'hF0); send(8'h23);
        send(8'h25); send(8'hF0); send(8'h25);
        idle(4);
        chk("t1_slot", {31'd0, slot}, 32'd1);
        chk("t1_partial", {30'd0, part}, 32'd0);
        chk("t1_we_low", {31'd0, we}, 32'd0);

        // 5 then E into slot 1, memory busy for 10 cycles, G pressed while pending
        rdy = 1'b0;
        exp_q.push_back({12'd65, 32'h0000_0064});
        send(8'h2E); send(8'hF0); send(8'h2E); send(8'h24);
        wait_we("t2_we_rise");
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (we && addr == 12'd65 && data == 32'h64) held++;
            kd = 8'h34;
            kp = (i == 3);
            tick();
        end
        kp = 1'b0;
        rdy = 1'b1;
        tick();
        idle(2);
        chk("t2_held_cycles", held, 32'd10);
        chk("t2_we_fall", {31'd0, we}, 32'd0);
        chk("t2_slot_wrap", {31'd0, slot}, 32'd0);
        chk("t2_partial", {30'd0, part}, 32'd0);

        // A then released 2: release filtered, only file held
        send(8'h1C); send(8'hF0); send(8'h1E);
        idle(3);
        chk("t3_partial", {30'd0, part}, 32'd1);
        chk("t3_slot", {31'd0, slot}, 32'd0);

        // Move right, C, Backspace twice; slot 0 keeps its A
        send(8'hE0); send(8'h74);
        idle(2);
        chk("t4_right", {31'd0, slot}, 32'd1);
        chk("t4_right_cleared", {30'd0, part}, 32'd0);
        send(8'h21);
        idle(2);
        chk("t4_partial_c", {30'd0, part}, 32'd1);
        send(8'h66);
        idle(2);
        chk("t4_bksp_clear", {30'd0, part}, 32'd0);
        chk("t4_bksp_stay", {31'd0, slot}, 32'd1);
        send(8'h66);
        idle(2);
        chk("t4_bksp_back", {31'd0, slot}, 32'd0);
        chk("t4_slot0_kept", {30'd0, part}, 32'd1);
        send(8'h66);
        idle(2);
        chk("t4_slot0_clear", {30'd0, part}, 32'd0);
        send(8'h66);
        idle(2);
        chk("t4_bksp_sat", {31'd0, slot}, 32'd0);

        // Esc arriving with ready in the same cycle drops the write
        rdy = 1'b0;
        send(8'h1C); send(8'h16);
        wait_we("t5_we_rise");
        send(8'h76);
        skip_mon = 1;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        skip_mon = 0;
        chk("t5_we_drop", {31'd0, we}, 32'd0);
        chk("t5_slot", {31'd0, slot}, 32'd0);
        chk("t5_partial", {30'd0, part}, 32'd0);
        rdy = 1'b1;
        idle(3);
        chk("t5_no_write", {31'd0, we}, 32'd0);
        rdy = 1'b0;

        // Three-slot arrow navigation
        send3(8'hE0); send3(8'h74); idle(2);
        chk("t6_right1", {30'd0, slot3}, 32'd1);
        send3(8'hE0); send3(8'h74); idle(2);
        chk("t6_right2", {30'd0, slot3}, 32'd2);
        send3(8'hE0); send3(8'h74); idle(2);
        chk("t6_right_wrap", {30'd0, slot3}, 32'd0);
        send3(8'hE0); send3(8'hF0); send3(8'h74); idle(2);
        chk("t6_ext_break", {30'd0, slot3}, 32'd0);
        send3(8'hE0); send3(8'h6B); idle(2);
        chk("t6_left_wrap", {30'd0, slot3}, 32'd2);

        // Reset while a write is pending
        send(8'h23); send(8'h25);
        wait_we("t7_we_rise");
        chk("t7_pend_data", data, 32'h1B);
        resetn = 1'b0;
        #1;
        chk("t7_rst_we", {31'd0, we}, 32'd0);
        chk("t7_rst_addr", {20'd0, addr}, 32'd64);
        chk("t7_rst_data", data, 32'd0);
        chk("t7_rst_slot", {31'd0, slot}, 32'd0);
        chk("t7_rst_partial", {30'd0, part}, 32'd0);
        tick();
        resetn = 1'b1;
        idle(3);
        chk("t7_after_we", {31'd0, we}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
